// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - word-organised data memory behind a single-outstanding req/rsp handshake
//
// Purpose: services byte/half/word loads and stores with a fixed, parameterised
// response latency. Requests are accepted only in IDLE. Illegal accesses are
// answered with rsp_err and never touch memory.
//
// Ports:
//   CLK        - clock, rising edge
//   RST_N      - asynchronous active-low reset (memory contents are kept)
//   req_valid  - request present          req_ready - responder idle, can accept
//   req_we     - 1 store / 0 load          req_ctrl  - size/sign code
//   req_addr   - byte address              req_wdata - store data, right-aligned
//   rsp_valid  - response present          rsp_ready - initiator takes response
//   rsp_rdata  - extended load data        rsp_err   - request rejected
module data_mem_responder #(
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 2
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_ctrl,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   // WAIT lasts LATENCY-1 cycles; the first RESP cycle performs the access
   // and its closing edge raises rsp_valid, giving exactly LATENCY edges.
   localparam int          LAT_WAIT_LAST = (LATENCY > 1) ? LATENCY - 2 : 0;
   localparam logic [3:0]  C_WAIT_LAST   = LAT_WAIT_LAST[3:0];
   localparam logic [30:0] C_DEPTH       = DEPTH_WORDS[30:0];

   logic [1:0]  r_state;
   logic [3:0]  r_cnt;
   logic        r_we;
   logic [2:0]  r_ctrl;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic        r_rsp_valid;
   logic [31:0] r_rsp_rdata;
   logic        r_rsp_err;

   logic [31:0] r_mem [0:DEPTH_WORDS-1];

   logic [AW-1:0] w_idx;
   logic [4:0]    w_shift;
   logic [31:0]   w_word;
   logic [31:0]   w_rd_sh;
   logic [31:0]   w_wdata_sh;
   logic [31:0]   w_load;
   logic [3:0]    w_be;
   logic          w_bad_ctrl;
   logic          w_misalign;
   logic          w_oob;
   logic          w_err;
   logic          w_mem_we;

   assign w_idx      = r_addr[AW+1:2];
   assign w_shift    = {r_addr[1:0], 3'b000};
   assign w_word     = r_mem[w_idx];
   assign w_rd_sh    = w_word >> w_shift;
   assign w_wdata_sh = r_wdata << w_shift;

   assign w_bad_ctrl = (r_ctrl == 3'b011) || (r_ctrl[2:1] == 2'b11);
   assign w_misalign = ((r_ctrl[1:0] == 2'b01) && r_addr[0]) ||
                       ((r_ctrl[1:0] == 2'b10) && (r_addr[1:0] != 2'b00));
   assign w_oob      = ({1'b0, r_addr[31:2]} >= C_DEPTH);
   assign w_err      = w_bad_ctrl || w_misalign || w_oob;

   // Memory is written only on the edge that raises rsp_valid, so a reset
   // arriving earlier drops the store without side effects.
   assign w_mem_we   = (r_state == S_RESP) && !r_rsp_valid && r_we && !w_err;

   always_comb begin
      w_be = 4'b0000;
      case (r_ctrl[1:0])
         2'b00:   w_be = 4'b0001 << r_addr[1:0];
         2'b01:   w_be = 4'b0011 << r_addr[1:0];
         2'b10:   w_be = 4'b1111;
         default: w_be = 4'b0000;
      endcase
   end

   always_comb begin
      w_load = 32'd0;
      case (r_ctrl)
         3'b000:  w_load = {{24{w_rd_sh[7]}}, w_rd_sh[7:0]};
         3'b001:  w_load = {{16{w_rd_sh[15]}}, w_rd_sh[15:0]};
         3'b010:  w_load = w_word;
         3'b100:  w_load = {24'd0, w_rd_sh[7:0]};
         3'b101:  w_load = {16'd0, w_rd_sh[15:0]};
         default: w_load = 32'd0;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state     <= S_IDLE;
         r_cnt       <= 4'd0;
         r_we        <= 1'b0;
         r_ctrl      <= 3'd0;
         r_addr      <= 32'd0;
         r_wdata     <= 32'd0;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= 32'd0;
         r_rsp_err   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (req_valid) begin
                  r_we    <= req_we;
                  r_ctrl  <= req_ctrl;
                  r_addr  <= req_addr;
                  r_wdata <= req_wdata;
                  r_cnt   <= 4'd0;
                  r_state <= (LATENCY > 1) ? S_WAIT : S_RESP;
               end
            end
            S_WAIT: begin
               if (r_cnt == C_WAIT_LAST) begin
                  r_cnt   <= 4'd0;
                  r_state <= S_RESP;
               end else begin
                  r_cnt <= r_cnt + 4'd1;
               end
            end
            S_RESP: begin
               if (!r_rsp_valid) begin
                  r_rsp_valid <= 1'b1;
                  r_rsp_err   <= w_err;
                  r_rsp_rdata <= (w_err || r_we) ? 32'd0 : w_load;
               end else if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_rsp_err   <= 1'b0;
                  r_rsp_rdata <= 32'd0;
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Storage is deliberately outside the reset domain: reset keeps contents.
   always_ff @(posedge CLK) begin
      if (w_mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata_sh[8*b +: 8];
         end
      end
   end

   assign req_ready = (r_state == S_IDLE);
   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rsp_rdata;
   assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - directed self-checking bench for data_mem_responder
module tb_data_mem_responder;

   logic        CLK = 1'b0;
   logic        RST_N;
   logic        req_valid, req_we, rsp_ready;
   logic [2:0]  req_ctrl;
   logic [31:0] req_addr, req_wdata;
   logic        req_ready, rsp_valid, rsp_err;
   logic [31:0] rsp_rdata;

   logic        l1_req_valid, l1_req_we, l1_rsp_ready;
   logic [2:0]  l1_req_ctrl;
   logic [31:0] l1_req_addr, l1_req_wdata;
   logic        l1_req_ready, l1_rsp_valid, l1_rsp_err;
   logic [31:0] l1_rsp_rdata;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 CLK = ~CLK;

   data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut (
      .CLK(CLK), .RST_N(RST_N),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_ctrl(req_ctrl), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
   );

   data_mem_responder #(.DEPTH_WORDS(16), .LATENCY(1)) dut_l1 (
      .CLK(CLK), .RST_N(RST_N),
      .req_valid(l1_req_valid), .req_ready(l1_req_ready), .req_we(l1_req_we),
      .req_ctrl(l1_req_ctrl), .req_addr(l1_req_addr), .req_wdata(l1_req_wdata),
      .rsp_valid(l1_rsp_valid), .rsp_ready(l1_rsp_ready),
      .rsp_rdata(l1_rsp_rdata), .rsp_err(l1_rsp_err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Present a request, release it after the accepting edge, count edges to rsp_valid.
   task automatic issue(input logic we, input logic [2:0] ctrl,
                        input logic [31:0] addr, input logic [31:0] wdata, output int lat);
      @(negedge CLK);
      req_valid = 1'b1; req_we = we; req_ctrl = ctrl; req_addr = addr; req_wdata = wdata;
      @(posedge CLK); #1;
      req_valid = 1'b0; req_we = 1'b0; req_ctrl = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
      lat = 0;
      while (!rsp_valid && lat < 40) begin
         @(posedge CLK); #1;
         lat++;
      end
      check("rsp_valid_seen", {31'd0, rsp_valid}, 32'd1);
   endtask

   task automatic complete(output logic [31:0] rdata, output logic err);
      rdata = rsp_rdata;
      err   = rsp_err;
      @(negedge CLK);
      rsp_ready = 1'b1;
      @(posedge CLK); #1;
      rsp_ready = 1'b0;
      check("req_ready_after_rsp", {31'd0, req_ready}, 32'd1);
      check("rsp_valid_after_rsp", {31'd0, rsp_valid}, 32'd0);
   endtask

   task automatic xfer(input string tag, input logic we, input logic [2:0] ctrl,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err);
      int          lat;
      logic [31:0] rd;
      logic        er;
      issue(we, ctrl, addr, wdata, lat);
      check({tag, "_lat"}, lat, 32'd2);
      complete(rd, er);
      check({tag, "_rdata"}, rd, exp_rdata);
      check({tag, "_err"}, {31'd0, er}, {31'd0, exp_err});
   endtask

   initial begin
      int          lat;
      logic [31:0] rd, hold;
      logic        er;

      RST_N = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_ctrl = 3'd0;
      req_addr = 32'd0; req_wdata = 32'd0; rsp_ready = 1'b0;
      l1_req_valid = 1'b0; l1_req_we = 1'b0; l1_req_ctrl = 3'd0;
      l1_req_addr = 32'd0; l1_req_wdata = 32'd0; l1_rsp_ready = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("rst_rsp_rdata", rsp_rdata, 32'd0);
      check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
      @(negedge CLK); RST_N = 1'b1;
      @(posedge CLK); #1;
      check("rst_req_ready", {31'd0, req_ready}, 32'd1);

      // Word store then loads of every size/sign.
      xfer("sw_10",  1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
      xfer("lw_10",  1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
      xfer("lb_13",  1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFFDE, 1'b0);
      xfer("lbu_13", 1'b0, 3'b100, 32'h13, 32'h0, 32'h000000DE, 1'b0);
      xfer("lh_10",  1'b0, 3'b001, 32'h10, 32'h0, 32'hFFFFBEEF, 1'b0);
      xfer("lhu_12", 1'b0, 3'b101, 32'h12, 32'h0, 32'h0000DEAD, 1'b0);
      xfer("lb_11",  1'b0, 3'b000, 32'h11, 32'h0, 32'hFFFFFFBE, 1'b0);
      xfer("sb_11",  1'b1, 3'b000, 32'h11, 32'h12345677, 32'h0, 1'b0);
      xfer("lw_10b", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD77EF, 1'b0);

      // Half store into the upper lanes.
      xfer("sw_14",  1'b1, 3'b010, 32'h14, 32'h00000000, 32'h0, 1'b0);
      xfer("sh_16",  1'b1, 3'b001, 32'h16, 32'hCAFE1234, 32'h0, 1'b0);
      xfer("lw_14",  1'b0, 3'b010, 32'h14, 32'h0, 32'h12340000, 1'b0);

      // Last legal word and the first out-of-range word.
      xfer("sw_3fc", 1'b1, 3'b010, 32'h3FC, 32'h5A5A5A5A, 32'h0, 1'b0);
      xfer("lw_3fc", 1'b0, 3'b010, 32'h3FC, 32'h0, 32'h5A5A5A5A, 1'b0);

      // Illegal requests.
      xfer("lw_12_mis",  1'b0, 3'b010, 32'h12, 32'h0, 32'h0, 1'b1);
      xfer("lh_11_mis",  1'b0, 3'b001, 32'h11, 32'h0, 32'h0, 1'b1);
      xfer("ctrl_011",   1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1);
      xfer("ctrl_111",   1'b0, 3'b111, 32'h10, 32'h0, 32'h0, 1'b1);
      xfer("lw_oob",     1'b0, 3'b010, 32'h400, 32'h0, 32'h0, 1'b1);
      xfer("sw_12_mis",  1'b1, 3'b010, 32'h12, 32'h0, 32'h0, 1'b1);
      xfer("sw_oob",     1'b1, 3'b010, 32'h400, 32'h0, 32'h0, 1'b1);
      xfer("lw_10_keep", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD77EF, 1'b0);

      // Back-pressure: response held, extra request ignored.
      issue(1'b0, 3'b010, 32'h10, 32'h0, lat);
      hold = rsp_rdata;
      check("stall_rdata", hold, 32'hDEAD77EF);
      for (int i = 0; i < 5; i++) begin
         @(negedge CLK);
         req_valid = 1'b1; req_we = 1'b1; req_ctrl = 3'b010;
         req_addr = 32'h10; req_wdata = 32'h0;
         @(posedge CLK); #1;
         check("stall_valid", {31'd0, rsp_valid}, 32'd1);
         check("stall_rdata_hold", rsp_rdata, hold);
         check("stall_req_ready", {31'd0, req_ready}, 32'd0);
      end
      @(negedge CLK);
      req_valid = 1'b0; req_we = 1'b0;
      complete(rd, er);
      check("stall_after_rdata", rsp_rdata, 32'd0);
      xfer("lw_10_noig", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD77EF, 1'b0);

      // Reset during WAIT drops the store; memory survives the reset.
      xfer("sw_20", 1'b1, 3'b010, 32'h20, 32'h11223344, 32'h0, 1'b0);
      @(negedge CLK);
      req_valid = 1'b1; req_we = 1'b1; req_ctrl = 3'b010;
      req_addr = 32'h20; req_wdata = 32'hAAAAAAAA;
      @(posedge CLK); #1;
      req_valid = 1'b0; req_we = 1'b0;
      check("pre_rst_req_ready", {31'd0, req_ready}, 32'd0);
      RST_N = 1'b0;
      #1;
      check("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("mid_rst_rsp_rdata", rsp_rdata, 32'd0);
      check("mid_rst_rsp_err", {31'd0, rsp_err}, 32'd0);
      check("mid_rst_req_ready", {31'd0, req_ready}, 32'd1);
      @(negedge CLK); RST_N = 1'b1;
      repeat (3) @(posedge CLK);
      #1;
      check("post_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      xfer("lw_20_keep", 1'b0, 3'b010, 32'h20, 32'h0, 32'h11223344, 1'b0);
      xfer("lw_10_rst",  1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD77EF, 1'b0);

      // LATENCY = 1 instance: response on the edge after acceptance.
      @(negedge CLK);
      l1_req_valid = 1'b1; l1_req_we = 1'b1; l1_req_ctrl = 3'b010;
      l1_req_addr = 32'h4; l1_req_wdata = 32'h01020304;
      @(posedge CLK); #1;
      l1_req_valid = 1'b0; l1_req_we = 1'b0;
      check("l1_sw_edge0_valid", {31'd0, l1_rsp_valid}, 32'd0);
      @(posedge CLK); #1;
      check("l1_sw_edge1_valid", {31'd0, l1_rsp_valid}, 32'd1);
      check("l1_sw_err", {31'd0, l1_rsp_err}, 32'd0);
      @(negedge CLK); l1_rsp_ready = 1'b1;
      @(posedge CLK); #1;
      l1_rsp_ready = 1'b0;
      check("l1_req_ready", {31'd0, l1_req_ready}, 32'd1);
      @(negedge CLK);
      l1_req_valid = 1'b1; l1_req_ctrl = 3'b100; l1_req_addr = 32'h6;
      @(posedge CLK); #1;
      l1_req_valid = 1'b0;
      check("l1_lbu_edge0_valid", {31'd0, l1_rsp_valid}, 32'd0);
      @(posedge CLK); #1;
      check("l1_lbu_edge1_valid", {31'd0, l1_rsp_valid}, 32'd1);
      check("l1_lbu_rdata", l1_rsp_rdata, 32'h00000002);
      @(negedge CLK); l1_rsp_ready = 1'b1;
      @(posedge CLK); #1;
      l1_rsp_ready = 1'b0;
      check("l1_rdata_idle", l1_rsp_rdata, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
